// File: rtl/mips_next_pc_unit.sv
// ---------------------------------------------------------------------------
// mips_next_pc_unit
//
// Program-counter register and next-PC generator for the fetch stage.
// Selects between sequential, branch, jump and jump-register targets, drives
// a fetch request handshake, honours a hazard stall and traps misaligned
// jump-register targets into a sticky error state.
//
// Optional feature (compile-time macro MIPS_NPC_RAS_EN): a circular
// return-address stack that records JAL/JALR return addresses and checks
// them against JR returns. Without the macro, ras_top and ras_mismatch are
// tied to 0 and link/ret_hint are ignored.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   fetch_ready   instruction memory accepts the current pc
//   stall         hazard hold, pc does not advance
//   sel           next-pc source: 00 seq, 01 branch, 10 jump, 11 jump-register
//   br_taken      branch condition, qualifies sel=01
//   imm           branch word offset (sign-extended)
//   jidx          jump instruction index
//   jr_addr       register jump target
//   link          current jump is JAL/JALR (push hint)
//   ret_hint      current JR is a return (pop hint)
//   err_clr       clears the sticky misalignment error
//   pc            current fetch address
//   pc_plus       pc + instruction size
//   fetch_valid   pc is a valid fetch request
//   redirect      pulse: last pc update was non-sequential
//   misalign_err  sticky misaligned jump-register flag
//   ras_top       predicted return address (0 when empty)
//   ras_mismatch  pulse: popped prediction differed from jr_addr
// ---------------------------------------------------------------------------
module mips_next_pc_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       IDX_W     = 26,
  parameter int unsigned       ALIGN     = 2,
  parameter int unsigned       IMM_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready,
  input  logic              stall,
  input  logic [1:0]        sel,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  imm,
  input  logic [IDX_W-1:0]  jidx,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              link,
  input  logic              ret_hint,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              fetch_valid,
  output logic              redirect,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_mismatch
);

  // Masks are used instead of part-selects so that ALIGN=0 and
  // ADDR_W == IDX_W+ALIGN both elaborate cleanly.
  localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(1) << ALIGN;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = INSN_BYTES - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REGION_MASK =
    ~((ADDR_W'(1) << (IDX_W + ALIGN)) - ADDR_W'(1));

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t            state;
  logic              adv;
  logic              jr_bad;
  logic              nonseq;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus = pc + INSN_BYTES;
  assign adv     = fetch_valid & fetch_ready & ~stall;
  assign jr_bad  = (sel == 2'b11) && ((jr_addr & ALIGN_MASK) != '0);

  always_comb begin
    br_off  = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << ALIGN;
    br_tgt  = pc_plus + br_off;
    jmp_tgt = (pc_plus & REGION_MASK) | (ADDR_W'(jidx) << ALIGN);
    next_pc = pc_plus;
    nonseq  = 1'b0;
    unique case (sel)
      2'b00: begin
        next_pc = pc_plus;
        nonseq  = 1'b0;
      end
      2'b01: begin
        next_pc = br_taken ? br_tgt : pc_plus;
        nonseq  = br_taken;
      end
      2'b10: begin
        next_pc = jmp_tgt;
        nonseq  = 1'b1;
      end
      2'b11: begin
        next_pc = jr_addr;
        nonseq  = 1'b1;
      end
      default: begin
        next_pc = pc_plus;
        nonseq  = 1'b0;
      end
    endcase
  end

  // INIT spends one edge with fetch_valid low before RUN; leaving TRAP goes
  // back through INIT so the error clears one edge before fetch resumes.
  // A misaligned JR that coincides with err_clr leaves the error clear and
  // the pc held (the bad target is never loaded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      redirect <= 1'b0;
      unique case (state)
        ST_INIT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (adv) begin
            if (jr_bad) begin
              if (!err_clr) begin
                state        <= ST_TRAP;
                misalign_err <= 1'b1;
                fetch_valid  <= 1'b0;
              end
            end else begin
              pc       <= next_pc;
              redirect <= nonseq;
            end
          end
        end
        ST_TRAP: begin
          if (err_clr) begin
            state        <= ST_INIT;
            misalign_err <= 1'b0;
          end
        end
        default: begin
          state        <= ST_INIT;
          fetch_valid  <= 1'b0;
          misalign_err <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIPS_NPC_RAS_EN
  localparam int unsigned RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_ptr;
  logic [RAS_AW-1:0] ras_ptr_inc;
  logic [RAS_AW-1:0] ras_ptr_dec;
  logic [RAS_CW-1:0] ras_cnt;
  logic              do_push;
  logic              do_pop;

  // ras_ptr always addresses the current top entry; the power-of-two depth
  // lets the pointer wrap naturally so a push when full overwrites the oldest.
  always_comb begin
    ras_ptr_inc = ras_ptr + 1'b1;
    ras_ptr_dec = ras_ptr - 1'b1;
    do_push     = adv & sel[1] & link;
    do_pop      = adv & (sel == 2'b11) & ret_hint & (ras_cnt != '0);
  end

  assign ras_top = (ras_cnt == '0) ? '0 : ras_mem[ras_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr      <= '0;
      ras_cnt      <= '0;
      ras_mismatch <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      ras_mismatch <= do_pop && (ras_mem[ras_ptr] != jr_addr);
      unique case ({do_pop, do_push})
        2'b10: begin
          ras_ptr <= ras_ptr_dec;
          ras_cnt <= ras_cnt - 1'b1;
        end
        2'b01: begin
          ras_ptr              <= ras_ptr_inc;
          ras_mem[ras_ptr_inc] <= pc_plus;
          if (ras_cnt != RAS_CW'(RAS_DEPTH)) begin
            ras_cnt <= ras_cnt + 1'b1;
          end
        end
        // Pop then push lands the new entry in the slot just vacated.
        2'b11: begin
          ras_mem[ras_ptr] <= pc_plus;
        end
        default: begin
        end
      endcase
    end
  end
`else
  logic unused_ras_hints;
  assign unused_ras_hints = link ^ ret_hint;
  assign ras_top          = '0;
  assign ras_mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_mips_next_pc_unit.sv
module tb_mips_next_pc_unit;

  localparam int unsigned RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm = '0;
  logic [25:0] jidx = '0;
  logic [31:0] jr_addr = '0;
  logic        link = 1'b0;
  logic        ret_hint = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] pc, pc_plus, ras_top;
  logic        fetch_valid, redirect, misalign_err, ras_mismatch;

  always #5 clk = ~clk;

  mips_next_pc_unit #(
    .ADDR_W   (32),
    .IDX_W    (26),
    .ALIGN    (2),
    .IMM_W    (16),
    .RESET_PC (32'h0000_0000),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .sel         (sel),
    .br_taken    (br_taken),
    .imm         (imm),
    .jidx        (jidx),
    .jr_addr     (jr_addr),
    .link        (link),
    .ret_hint    (ret_hint),
    .err_clr     (err_clr),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .fetch_valid (fetch_valid),
    .redirect    (redirect),
    .misalign_err(misalign_err),
    .ras_top     (ras_top),
    .ras_mismatch(ras_mismatch)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_fv, m_err, m_redir, m_mm;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_top();
`ifdef MIPS_NPC_RAS_EN
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_fv = 0; m_err = 0; m_redir = 0; m_mm = 0;
    m_ras.delete();
  endtask

  task automatic set_in(input logic [1:0] s, input logic bt, input logic [15:0] im,
                        input logic [25:0] ji, input logic [31:0] ja,
                        input logic lk, input logic rh, input logic clr);
    sel = s; br_taken = bt; imm = im; jidx = ji; jr_addr = ja;
    link = lk; ret_hint = rh; err_clr = clr;
  endtask

  // One clock: predict the next state from the rules, clock, compare all outputs.
  task automatic step();
    logic [31:0] seqt, tgt, popped;
    int          off;
    bit          adv, bad, nfv, nerr;
    seqt = m_pc + 32'd4;
    adv  = m_fv && fetch_ready && !stall;
    nfv  = m_fv;
    nerr = m_err;
    m_redir = 0;
    m_mm    = 0;
    if (!m_fv && !m_err) nfv = 1;
    if (m_err && err_clr) nerr = 0;
    if (adv) begin
      off = $signed(imm);
      case (sel)
        2'd0:    tgt = seqt;
        2'd1:    tgt = br_taken ? seqt + 32'(off * 4) : seqt;
        2'd2:    tgt = (seqt & 32'hF000_0000) | (32'(jidx) * 4);
        default: tgt = jr_addr;
      endcase
      bad = (sel == 2'd3) && (jr_addr % 4 != 0);
      if (bad) begin
        if (!err_clr) begin nerr = 1; nfv = 0; end
      end else begin
        m_pc    = tgt;
        m_redir = (sel >= 2'd2) || (sel == 2'd1 && br_taken);
      end
`ifdef MIPS_NPC_RAS_EN
      if (sel == 2'd3 && ret_hint && m_ras.size() > 0) begin
        popped = m_ras.pop_back();
        m_mm   = (popped != jr_addr);
      end
      if (sel >= 2'd2 && link) begin
        m_ras.push_back(seqt);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
`endif
    end
    m_fv  = nfv;
    m_err = nerr;
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    chk("ras_top", ras_top, model_top());
    chk("ras_mismatch", 32'(ras_mismatch), 32'(m_mm));
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_err", 32'(misalign_err), 32'h0);
    chk("rst_ras_top", ras_top, 32'h0);
    chk("rst_ras_mm", 32'(ras_mismatch), 32'h0);
    rst_n = 1'b1;

    // Reset release and sequential fetch
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0);
    step(); chk("init_fv", 32'(fetch_valid), 32'h1); chk("init_pc", pc, 32'h0);
    step(); chk("seq_pc1", pc, 32'h4);
    step(); chk("seq_pc2", pc, 32'h8); chk("seq_redir", 32'(redirect), 32'h0);

    // Wrap at the top of the address space
    set_in(2'd3, 0, '0, '0, 32'hFFFF_FFFC, 0, 0, 0); step();
    chk("wrap_pc_plus", pc_plus, 32'h0);
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0); step(); chk("wrap_pc", pc, 32'h0);

    // Jump within the current region
    set_in(2'd3, 0, '0, '0, 32'h1000_0040, 0, 0, 0); step();
    set_in(2'd2, 0, '0, 26'h100, '0, 0, 0, 0); step();
    chk("jmp_pc", pc, 32'h1000_0400); chk("jmp_redir", 32'(redirect), 32'h1);
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0); step();
    chk("jmp_redir_end", 32'(redirect), 32'h0);

    // Branch taken / not taken
    set_in(2'd3, 0, '0, '0, 32'h100, 0, 0, 0); step();
    set_in(2'd1, 1, 16'hFFFC, '0, '0, 0, 0, 0); step(); chk("br_taken_pc", pc, 32'hF4);
    set_in(2'd3, 0, '0, '0, 32'h100, 0, 0, 0); step();
    set_in(2'd1, 0, 16'hFFFC, '0, '0, 0, 0, 0); step(); chk("br_ntaken_pc", pc, 32'h104);

    // Stall holds pc; values on the first unstalled edge are used
    stall = 1'b1;
    set_in(2'd2, 0, '0, 26'h3FF, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_pc", pc, 32'h104);
    end
    stall = 1'b0;
    set_in(2'd2, 0, '0, 26'h200, '0, 0, 0, 0); step(); chk("unstall_pc", pc, 32'h800);

    // Misaligned jump-register trap and clear
    set_in(2'd3, 0, '0, '0, 32'h2002, 0, 0, 0); step();
    chk("mis_pc", pc, 32'h800); chk("mis_err", 32'(misalign_err), 32'h1);
    chk("mis_fv", 32'(fetch_valid), 32'h0);
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0); step();
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 1); step();
    chk("clr_err", 32'(misalign_err), 32'h0); chk("clr_fv0", 32'(fetch_valid), 32'h0);
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0); step();
    chk("clr_fv1", 32'(fetch_valid), 32'h1);
    set_in(2'd3, 0, '0, '0, 32'h2000, 0, 0, 0); step(); chk("jr_ok_pc", pc, 32'h2000);

`ifdef MIPS_NPC_RAS_EN
    // Five JALs into a depth-4 stack, then returns
    set_in(2'd3, 0, '0, '0, 32'h10, 0, 0, 0); step();
    set_in(2'd2, 0, '0, 26'h8, '0, 1, 0, 0); step();
    set_in(2'd2, 0, '0, 26'hC, '0, 1, 0, 0); step();
    set_in(2'd2, 0, '0, 26'h10, '0, 1, 0, 0); step();
    set_in(2'd2, 0, '0, 26'h14, '0, 1, 0, 0); step();
    set_in(2'd2, 0, '0, 26'h40, '0, 1, 0, 0); step();
    chk("ras_top5", ras_top, 32'h54);
    set_in(2'd3, 0, '0, '0, 32'h54, 0, 1, 0); step();
    chk("ras_pop1_mm", 32'(ras_mismatch), 32'h0);
    set_in(2'd3, 0, '0, '0, 32'h99, 0, 1, 0); step();
    chk("ras_pop2_mm", 32'(ras_mismatch), 32'h1);
    chk("ras_top_after2", ras_top, 32'h34);
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 1); step();
    set_in(2'd0, 0, '0, '0, '0, 0, 0, 0); step();
    set_in(2'd3, 0, '0, '0, 32'h34, 0, 1, 0); step();
    chk("ras_pop3_mm", 32'(ras_mismatch), 32'h0); chk("ras_top3", ras_top, 32'h24);
    set_in(2'd3, 0, '0, '0, 32'h24, 0, 1, 0); step();
    chk("ras_pop4_mm", 32'(ras_mismatch), 32'h0); chk("ras_empty", ras_top, 32'h0);
    set_in(2'd3, 0, '0, '0, 32'h14, 0, 1, 0); step();
    chk("ras_pop_empty_mm", 32'(ras_mismatch), 32'h0);
`endif

    // Asynchronous reset while a redirect is being reported
    set_in(2'd2, 0, '0, 26'h123, '0, 1, 0, 0); step();
    chk("pre_rst_redir", 32'(redirect), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_redir", 32'(redirect), 32'h0);
    chk("arst_err", 32'(misalign_err), 32'h0);
    chk("arst_fv", 32'(fetch_valid), 32'h0);
    chk("arst_ras_top", ras_top, 32'h0);
    model_reset();
    #3 rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      sel      = 2'($urandom_range(0, 3));
      br_taken = 1'($urandom);
      imm      = 16'($urandom);
      jidx     = 26'($urandom);
      jr_addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) jr_addr[1:0] = 2'($urandom_range(1, 3));
`ifdef MIPS_NPC_RAS_EN
      if ($urandom_range(0, 1) == 0) jr_addr = model_top();
`endif
      link        = 1'($urandom);
      ret_hint    = 1'($urandom);
      err_clr     = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
